// File: rtl/frag_fwd_ctrl.sv
// Forwarding and load-use hazard controller at the ID/EX boundary.
// Tracks EX and MEM producers and issues registered operand-select codes
// for the instruction entering EX. Inserts one bubble per load-use hazard.
//
// Handshake note: there is no valid/ready pair here. id_valid qualifies the
// ID inputs every cycle. stall tells upstream to re-present the same ID
// instruction next cycle. hold freezes everything and overrides flush/stall.
module frag_fwd_ctrl #(
   parameter int REGADDR_W = 5,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REGADDR_W-1:0] id_rs1,
   input  logic [REGADDR_W-1:0] id_rs2,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic [REGADDR_W-1:0] id_rd,
   input  logic                 id_regwrite,
   input  logic                 id_is_load,
   input  logic                 flush,
   input  logic                 hold,
   output logic [1:0]           fwd_sel_a,
   output logic [1:0]           fwd_sel_b,
   output logic                 ex_bubble,
   output logic                 stall,
   output logic [CNT_W-1:0]     lu_stall_cnt
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EXM = 2'b01;
   localparam logic [1:0] SEL_MWB = 2'b10;

   // EX entry
   logic                 ex_valid_q, ex_valid_d;
   logic [REGADDR_W-1:0] ex_rd_q, ex_rd_d;
   logic                 ex_regwrite_q, ex_regwrite_d;
   logic                 ex_is_load_q, ex_is_load_d;
   // MEM entry
   logic                 mem_valid_q, mem_valid_d;
   logic [REGADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic                 mem_regwrite_q, mem_regwrite_d;
   // Selects belonging to the EX entry
   logic [1:0]           sel_a_q, sel_a_d;
   logic [1:0]           sel_b_q, sel_b_d;
   // Load-use bubble counter
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic ex_m1, ex_m2, mem_m1, mem_m2;
   logic hazard;
   logic [1:0] sel_a_calc, sel_b_calc;

   // Producer matching: x0 never forwards, unused sources never match.
   always_comb begin
      ex_m1  = ex_valid_q & ex_regwrite_q & (ex_rd_q == id_rs1) &
               (ex_rd_q != '0) & id_rs1_used;
      ex_m2  = ex_valid_q & ex_regwrite_q & (ex_rd_q == id_rs2) &
               (ex_rd_q != '0) & id_rs2_used;
      mem_m1 = mem_valid_q & mem_regwrite_q & (mem_rd_q == id_rs1) &
               (mem_rd_q != '0) & id_rs1_used;
      mem_m2 = mem_valid_q & mem_regwrite_q & (mem_rd_q == id_rs2) &
               (mem_rd_q != '0) & id_rs2_used;
   end

   // Hazard detection; hold, flush and reset all suppress the stall request.
   always_comb begin
      hazard = id_valid & ex_is_load_q & (ex_m1 | ex_m2);
      stall  = hazard & ~flush & ~hold & ~rst;
   end

   // Select codes for the ID instruction; the youngest producer (EX) wins.
   always_comb begin
      sel_a_calc = SEL_RF;
      sel_b_calc = SEL_RF;
      if (ex_m1 && !ex_is_load_q) sel_a_calc = SEL_EXM;
      else if (mem_m1)            sel_a_calc = SEL_MWB;
      if (ex_m2 && !ex_is_load_q) sel_b_calc = SEL_EXM;
      else if (mem_m2)            sel_b_calc = SEL_MWB;
   end

   // Next-state: hold > flush > stall > normal advance.
   always_comb begin
      ex_valid_d     = ex_valid_q;
      ex_rd_d        = ex_rd_q;
      ex_regwrite_d  = ex_regwrite_q;
      ex_is_load_d   = ex_is_load_q;
      mem_valid_d    = mem_valid_q;
      mem_rd_d       = mem_rd_q;
      mem_regwrite_d = mem_regwrite_q;
      sel_a_d        = sel_a_q;
      sel_b_d        = sel_b_q;
      cnt_d          = cnt_q;
      if (hold) begin
         // everything frozen
      end else begin
         mem_valid_d    = ex_valid_q;
         mem_rd_d       = ex_rd_q;
         mem_regwrite_d = ex_regwrite_q;
         if (flush || stall) begin
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_is_load_d  = 1'b0;
            sel_a_d       = SEL_RF;
            sel_b_d       = SEL_RF;
            if (!flush && cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            ex_valid_d    = id_valid;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
            ex_is_load_d  = id_is_load;
            sel_a_d       = id_valid ? sel_a_calc : SEL_RF;
            sel_b_d       = id_valid ? sel_b_calc : SEL_RF;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_is_load_q   <= 1'b0;
         mem_valid_q    <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         sel_a_q        <= SEL_RF;
         sel_b_q        <= SEL_RF;
         cnt_q          <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_rd_q        <= ex_rd_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_is_load_q   <= ex_is_load_d;
         mem_valid_q    <= mem_valid_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         sel_a_q        <= sel_a_d;
         sel_b_q        <= sel_b_d;
         cnt_q          <= cnt_d;
      end
   end

   assign fwd_sel_a    = sel_a_q;
   assign fwd_sel_b    = sel_b_q;
   assign ex_bubble    = ~ex_valid_q;
   assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_frag_fwd_ctrl.sv
// Bench for frag_fwd_ctrl: directed scenarios plus a randomized run, all
// checked against an instruction-level pipeline model (EX and MEM slots).
// A second instance with a 2-bit counter shares the stimulus for saturation.
module tb_frag_fwd_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_rs1_used, id_rs2_used;
   logic       id_regwrite, id_is_load;
   logic       flush, hold;

   logic [1:0]  fwd_sel_a, fwd_sel_b;
   logic        ex_bubble, stall;
   logic [15:0] lu_stall_cnt;

   logic [1:0]  s_sel_a, s_sel_b;
   logic        s_ex_bubble, s_stall;
   logic [1:0]  s_cnt;

   int errors = 0;
   int checks = 0;

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   frag_fwd_ctrl #(.REGADDR_W(5), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
      .flush(flush), .hold(hold),
      .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .ex_bubble(ex_bubble), .stall(stall), .lu_stall_cnt(lu_stall_cnt)
   );

   frag_fwd_ctrl #(.REGADDR_W(5), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
      .flush(flush), .hold(hold),
      .fwd_sel_a(s_sel_a), .fwd_sel_b(s_sel_b),
      .ex_bubble(s_ex_bubble), .stall(s_stall), .lu_stall_cnt(s_cnt)
   );

   // ---------------- reference model ----------------
   typedef struct {
      bit v;
      int rd;
      bit rw;
      bit ld;
   } instr_t;

   instr_t m_ex, m_mem;
   int m_sel_a, m_sel_b;
   int m_cnt;
   bit m_stall;
   bit last_stall;

   // Distance of the youngest in-flight writer of rs: 1 = EX, 2 = MEM, 0 = none.
   function automatic int producer_dist(int rs, bit used);
      if (!used || rs == 0) return 0;
      if (m_ex.v && m_ex.rw && m_ex.rd == rs) return 1;
      if (m_mem.v && m_mem.rw && m_mem.rd == rs) return 2;
      return 0;
   endfunction

   function automatic bit model_hazard();
      bit h;
      h = 0;
      if (id_valid && m_ex.ld) begin
         if (producer_dist(int'(id_rs1), id_rs1_used) == 1) h = 1;
         if (producer_dist(int'(id_rs2), id_rs2_used) == 1) h = 1;
      end
      return h;
   endfunction

   task automatic model_reset();
      m_ex = '{0, 0, 0, 0};
      m_mem = '{0, 0, 0, 0};
      m_sel_a = 0;
      m_sel_b = 0;
      m_cnt = 0;
   endtask

   task automatic model_step();
      int da, db;
      if (rst) begin
         model_reset();
      end else if (hold) begin
      end else if (flush || m_stall) begin
         m_mem = m_ex;
         m_ex.v = 0;
         m_sel_a = 0;
         m_sel_b = 0;
         if (!flush) m_cnt++;
      end else begin
         da = producer_dist(int'(id_rs1), id_rs1_used);
         db = producer_dist(int'(id_rs2), id_rs2_used);
         m_mem = m_ex;
         m_ex = '{id_valid, int'(id_rd), id_regwrite, id_is_load};
         m_sel_a = id_valid ? da : 0;
         m_sel_b = id_valid ? db : 0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_id(bit v, int rs1, int rs2, int rd, bit rw, bit ld);
      id_valid = v;
      id_rs1 = 5'(rs1);
      id_rs2 = 5'(rs2);
      id_rd = 5'(rd);
      id_regwrite = rw;
      id_is_load = ld;
      id_rs1_used = 1'b1;
      id_rs2_used = 1'b1;
   endtask

   // One clock: check stall before the edge, then registered outputs after it.
   task automatic cycle(bit r, bit fl, bit hd);
      int exp_cnt16, exp_cnt2;
      @(negedge clk);
      rst = r;
      flush = fl;
      hold = hd;
      #1;
      m_stall = !rst && !hold && !flush && model_hazard();
      last_stall = stall;
      checks++;
      if (stall !== m_stall) begin
         errors++;
         $display("FAIL stall t=%0t got %b exp %b", $time, stall, m_stall);
      end
      @(posedge clk);
      model_step();
      #1;
      exp_cnt16 = (m_cnt > 65535) ? 65535 : m_cnt;
      exp_cnt2 = (m_cnt > 3) ? 3 : m_cnt;
      checks++;
      if (fwd_sel_a !== 2'(m_sel_a)) begin
         errors++;
         $display("FAIL sel_a t=%0t got %b exp %0d", $time, fwd_sel_a, m_sel_a);
      end
      checks++;
      if (fwd_sel_b !== 2'(m_sel_b)) begin
         errors++;
         $display("FAIL sel_b t=%0t got %b exp %0d", $time, fwd_sel_b, m_sel_b);
      end
      checks++;
      if (ex_bubble !== !m_ex.v) begin
         errors++;
         $display("FAIL ex_bubble t=%0t got %b exp %b", $time, ex_bubble, !m_ex.v);
      end
      checks++;
      if (lu_stall_cnt !== 16'(exp_cnt16)) begin
         errors++;
         $display("FAIL cnt t=%0t got %0d exp %0d", $time, lu_stall_cnt, exp_cnt16);
      end
      checks++;
      if (s_cnt !== 2'(exp_cnt2)) begin
         errors++;
         $display("FAIL sat_cnt t=%0t got %0d exp %0d", $time, s_cnt, exp_cnt2);
      end
   endtask

   task automatic do_reset();
      set_id(1, 1, 2, 3, 1, 1);
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      set_id(0, 0, 0, 0, 0, 0);
   endtask

   task automatic expect_val(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      expect_val("reset_sel_a", int'(fwd_sel_a), 0);
      expect_val("reset_sel_b", int'(fwd_sel_b), 0);
      expect_val("reset_bubble", int'(ex_bubble), 1);
      expect_val("reset_stall", int'(last_stall), 0);
      expect_val("reset_cnt", int'(lu_stall_cnt), 0);
   endtask

   task automatic test_ex_fwd();
      do_reset();
      set_id(1, 1, 2, 5, 1, 0); cycle(0, 0, 0);   // add x5
      set_id(1, 5, 6, 8, 1, 0); cycle(0, 0, 0);   // sub rs1=5 rs2=6
      expect_val("ex_fwd_stall", int'(last_stall), 0);
      expect_val("ex_fwd_sel_a", int'(fwd_sel_a), 1);
      expect_val("ex_fwd_sel_b", int'(fwd_sel_b), 0);
   endtask

   task automatic test_mem_priority();
      do_reset();
      set_id(1, 1, 1, 7, 1, 0); cycle(0, 0, 0);
      set_id(1, 1, 1, 7, 1, 0); cycle(0, 0, 0);
      set_id(1, 7, 1, 9, 1, 0); cycle(0, 0, 0);
      expect_val("prio_youngest", int'(fwd_sel_a), 1);
      set_id(1, 1, 1, 7, 1, 0); cycle(0, 0, 0);
      set_id(1, 1, 1, 10, 1, 0); cycle(0, 0, 0);
      set_id(1, 7, 7, 11, 1, 0); cycle(0, 0, 0);
      expect_val("mem_sel_a", int'(fwd_sel_a), 2);
      expect_val("mem_sel_b_same", int'(fwd_sel_b), 2);
      set_id(1, 1, 1, 0, 1, 0); cycle(0, 0, 0);   // writes x0
      set_id(1, 0, 0, 12, 1, 0); cycle(0, 0, 0);
      expect_val("x0_sel_a", int'(fwd_sel_a), 0);
      expect_val("x0_sel_b", int'(fwd_sel_b), 0);
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1, 1, 1, 3, 1, 1); cycle(0, 0, 0);   // lw x3
      set_id(1, 4, 3, 6, 1, 0); cycle(0, 0, 0);   // uses x3 as rs2
      expect_val("lu_stall", int'(last_stall), 1);
      expect_val("lu_bubble", int'(ex_bubble), 1);
      cycle(0, 0, 0);                             // same instr re-presented
      expect_val("lu_stall_once", int'(last_stall), 0);
      expect_val("lu_sel_b", int'(fwd_sel_b), 2);
      expect_val("lu_cnt", int'(lu_stall_cnt), 1);
   endtask

   task automatic test_flush_hold();
      do_reset();
      set_id(1, 1, 1, 3, 1, 1); cycle(0, 0, 0);
      set_id(1, 3, 1, 6, 1, 0); cycle(0, 1, 0);   // flush over hazard
      expect_val("flush_stall", int'(last_stall), 0);
      expect_val("flush_bubble", int'(ex_bubble), 1);
      expect_val("flush_cnt", int'(lu_stall_cnt), 0);
      set_id(1, 1, 2, 5, 1, 0); cycle(0, 0, 0);   // add x5
      set_id(1, 5, 6, 8, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1);
         expect_val("hold_sel_a", int'(fwd_sel_a), 0);
         expect_val("hold_bubble", int'(ex_bubble), 0);
      end
      cycle(0, 0, 0);
      expect_val("resume_sel_a", int'(fwd_sel_a), 1);
      set_id(1, 1, 1, 3, 1, 1); cycle(0, 0, 0);
      set_id(1, 3, 1, 6, 1, 0); cycle(0, 0, 1);   // hold over hazard
      expect_val("hold_stall", int'(last_stall), 0);
      cycle(0, 0, 0);
      expect_val("hold_then_stall", int'(last_stall), 1);
      cycle(0, 0, 0);
      expect_val("hold_resume_sel_a", int'(fwd_sel_a), 2);
   endtask

   task automatic test_back_to_back_sat();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_id(1, 1, 1, 3, 1, 1); cycle(0, 0, 0);
         set_id(1, 3, 2, 4, 1, 1); cycle(0, 0, 0);   // dependent is itself a load
         cycle(0, 0, 0);
         set_id(1, 4, 0, 9, 1, 0); cycle(0, 0, 0);   // depends on the second load
         cycle(0, 0, 0);
      end
      expect_val("b2b_cnt", int'(lu_stall_cnt), 10);
      expect_val("sat_cnt", int'(s_cnt), 3);
   endtask

   task automatic test_random();
      bit r, fl, hd;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (!last_stall || $urandom_range(0, 9) == 0) begin
            id_valid = ($urandom_range(0, 9) != 0);
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_rs1_used = ($urandom_range(0, 5) != 0);
            id_rs2_used = ($urandom_range(0, 5) != 0);
            id_regwrite = ($urandom_range(0, 4) != 0);
            id_is_load = ($urandom_range(0, 2) == 0);
         end
         r = ($urandom_range(0, 99) == 0);
         fl = ($urandom_range(0, 9) == 0);
         hd = ($urandom_range(0, 9) == 0);
         cycle(r, fl, hd);
      end
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      hold = 1'b0;
      last_stall = 1'b0;
      m_stall = 1'b0;
      set_id(0, 0, 0, 0, 0, 0);
      model_reset();
      test_reset();
      test_ex_fwd();
      test_mem_priority();
      test_load_use();
      test_flush_hold();
      test_back_to_back_sat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frag_fwd_ctrl.md
Name: frag_fwd_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage integer pipeline. Sits at the ID/EX boundary, directly upstream of the two EX-stage 3-input operand muxes.
- Tracks the destination registers of in-flight instructions in EX and MEM, and produces registered 2-bit operand select codes for the instruction entering EX.
- Detects load-use hazards and inserts a one-cycle bubble. Counts inserted load-use stalls.

Parameters:
- REGADDR_W, 5, register index width.
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REGADDR_W  source register 1 index.
- id_rs2  input  REGADDR_W  source register 2 index.
- id_rs1_used  input  1  instruction reads rs1.
- id_rs2_used  input  1  instruction reads rs2.
- id_rd  input  REGADDR_W  destination register index.
- id_regwrite  input  1  instruction writes rd.
- id_is_load  input  1  instruction is a load; result is available only at MEM/WB.
- flush  input  1  branch/jump redirect; kill the ID and EX instructions.
- hold  input  1  downstream freeze (memory wait); whole pipeline holds.
- fwd_sel_a  output  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_sel_b  output  2  EX operand B select, same encoding.
- ex_bubble  output  1  EX stage currently holds a bubble.
- stall  output  1  combinational; hold IF/ID this cycle.
- lu_stall_cnt  output  CNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset values: all tracking entries invalid; fwd_sel_a/b = 00; ex_bubble = 1; lu_stall_cnt = 0; stall = 0.
- Reset mid-operation discards all tracked instructions.
- Internal state:
  - EX entry {valid, rd, regwrite, is_load}.
  - MEM entry {valid, rd, regwrite}.
  - Registered selects belonging to the EX entry.
- Producer match: an entry matches source rs when the entry is valid, has regwrite=1, has rd==rs, rd!=0, and the source's used bit is set. Register x0 is never forwarded.
- Load-use hazard: id_valid, and the EX entry matches rs1 or rs2 with is_load=1.
  - stall = hazard & ~flush & ~hold.
- Select computation (next EX instruction vs current EX/MEM entries), per source:
  - EX entry match (non-load) -> 01. This entry becomes EX/MEM when the instruction enters EX.
  - Otherwise MEM entry match -> 10.
  - Otherwise -> 00.
  - EX match has priority over MEM match (youngest producer wins).
  - The WB-to-ID distance is not tracked; the regfile is write-first.
- Update rules at the rising edge, by priority:
  1. hold=1: all state, selects and the counter are unchanged. stall is 0 (hold dominates).
  2. flush=1: the EX entry becomes a bubble (valid=0, selects 00). MEM takes the old EX entry. No counter change.
  3. stall=1: the EX entry becomes a bubble with selects 00. MEM takes the old EX entry. The ID instruction is held by upstream. lu_stall_cnt increments, saturating at all-ones.
  4. Otherwise: MEM takes the EX entry. EX takes {id_valid, id_rd, id_regwrite, id_is_load} with the computed selects. A bubble (id_valid=0) yields selects 00.
- ex_bubble = ~EX.valid.
- Latency:
  - Selects are valid in the same cycle the instruction occupies EX, one edge after ID.
  - stall is combinational from the ID inputs and EX state; no added latency.
- After a load-use bubble, the dependent instruction is re-evaluated next cycle. The load is then in MEM, giving select 10.
- Back-to-back load-use (two dependents on consecutive loads) stalls once per hazard. The counter counts each one.
- Producers whose rd matches both rs1 and rs2 set both selects identically.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 -> fwd_sel_a=fwd_sel_b=00, ex_bubble=1, stall=0, lu_stall_cnt=0.
- EX-distance ALU hazard:
  - Issue add x5 (rd=5, regwrite), then sub with rs1=5, rs2=6.
  - -> sub in EX with fwd_sel_a=01, fwd_sel_b=00, no stall.
- MEM distance and priority:
  - rd=7, then rd=7, then rs1=7 -> sel_a=01 (youngest).
  - rd=7, unrelated, then rs1=7 -> sel_a=10.
  - rd=0 producer -> sel 00.
- Load-use:
  - lw rd=3 followed by rs2=3.
  - -> stall=1 for exactly one cycle, then ex_bubble=1.
  - -> next cycle the dependent enters EX with fwd_sel_b=10; lu_stall_cnt=1.
- Flush and hold:
  - flush during a load-use hazard -> stall=0, EX bubble, counter unchanged.
  - hold=1 for 3 cycles -> selects and entries frozen, stall=0.
  - Resuming -> identical sequence to the no-hold run.
- Counter saturation: with CNT_W=2, force 5 load-use hazards -> lu_stall_cnt stops at 3.
